// File: rtl/racalc_jobs_fifo.sv
// First-word-fall-through job FIFO between the HLS job generator and the racalc engine.
// Define RACALC_FIFO_STATS_EN to add the traffic/occupancy statistics ports.
module racalc_jobs_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [WIDTH-1:0]      racalc_jobs_V_cnt_ls_V_din,
  output logic                  racalc_jobs_V_cnt_ls_V_full_n,
  input  logic                  racalc_jobs_V_cnt_ls_V_write,
  output logic [WIDTH-1:0]      racalc_out_V_cnt_ls_V_dout,
  output logic                  racalc_out_V_cnt_ls_V_empty_n,
  input  logic                  racalc_out_V_cnt_ls_V_read,
  output logic [DEPTH_LOG2:0]   level
`ifdef RACALC_FIFO_STATS_EN
  ,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_rd_cnt,
  output logic [DEPTH_LOG2:0]   stat_hwm,
  output logic [15:0]           stat_wr_drop
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  rst_q_reg;
  logic                  full_n;
  logic                  empty_n;
  logic                  wr_accept;
  logic                  rd_accept;

  // Flags come from registers only; rst_q_reg holds the write side off for one cycle after reset.
  assign full_n    = !rst_q_reg && (level_reg != LEVEL_FULL);
  assign empty_n   = (level_reg != '0);
  assign wr_accept = racalc_jobs_V_cnt_ls_V_write && full_n;
  assign rd_accept = racalc_out_V_cnt_ls_V_read && empty_n;

  assign racalc_jobs_V_cnt_ls_V_full_n = full_n;
  assign racalc_out_V_cnt_ls_V_empty_n = empty_n;
  assign racalc_out_V_cnt_ls_V_dout    = empty_n ? mem_reg[rd_ptr_reg] : '0;
  assign level                         = level_reg;

  always_comb begin
    level_next = level_reg;
    case ({wr_accept, rd_accept})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    rst_q_reg <= ap_rst;
    if (ap_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge ap_clk) begin
    if (wr_accept) mem_reg[wr_ptr_reg] <= racalc_jobs_V_cnt_ls_V_din;
  end

`ifdef RACALC_FIFO_STATS_EN
  logic [31:0]         wr_cnt_reg;
  logic [31:0]         rd_cnt_reg;
  logic [DEPTH_LOG2:0] hwm_reg;
  logic [15:0]         wr_drop_reg;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      hwm_reg     <= '0;
      wr_drop_reg <= '0;
    end else begin
      if (wr_accept) wr_cnt_reg <= wr_cnt_reg + 32'd1;
      if (rd_accept) rd_cnt_reg <= rd_cnt_reg + 32'd1;
      if (level_next > hwm_reg) hwm_reg <= level_next;
      if (racalc_jobs_V_cnt_ls_V_write && !full_n && (wr_drop_reg != 16'hFFFF))
        wr_drop_reg <= wr_drop_reg + 16'd1;
    end
  end

  assign stat_wr_cnt  = wr_cnt_reg;
  assign stat_rd_cnt  = rd_cnt_reg;
  assign stat_hwm     = hwm_reg;
  assign stat_wr_drop = wr_drop_reg;
`endif

endmodule

// File: tb/tb_racalc_jobs_fifo.sv
// Bench for racalc_jobs_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_racalc_jobs_fifo;
  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   din = 8'h00;
  logic         wr  = 1'b0;
  logic         rd  = 1'b0;
  logic         full_n;
  logic         empty_n;
  logic [7:0]   dout;
  logic [DL2:0] level;
`ifdef RACALC_FIFO_STATS_EN
  logic [31:0]  stat_wr_cnt;
  logic [31:0]  stat_rd_cnt;
  logic [DL2:0] stat_hwm;
  logic [15:0]  stat_wr_drop;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: contents as a queue plus the stat totals.
  logic [7:0]  q[$];
  bit          m_rstq = 1'b1;
  int unsigned m_wr = 0, m_rd = 0, m_hwm = 0, m_drop = 0;

  always #5 clk = ~clk;

  racalc_jobs_fifo #(.DEPTH_LOG2(DL2), .WIDTH(8)) dut (
    .ap_clk                        (clk),
    .ap_rst                        (rst),
    .racalc_jobs_V_cnt_ls_V_din    (din),
    .racalc_jobs_V_cnt_ls_V_full_n (full_n),
    .racalc_jobs_V_cnt_ls_V_write  (wr),
    .racalc_out_V_cnt_ls_V_dout    (dout),
    .racalc_out_V_cnt_ls_V_empty_n (empty_n),
    .racalc_out_V_cnt_ls_V_read    (rd),
    .level                         (level)
`ifdef RACALC_FIFO_STATS_EN
    ,
    .stat_wr_cnt                   (stat_wr_cnt),
    .stat_rd_cnt                   (stat_rd_cnt),
    .stat_hwm                      (stat_hwm),
    .stat_wr_drop                  (stat_wr_drop)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk("level", 32'(level), 32'(q.size()));
    chk("full_n", 32'(full_n), 32'(!m_rstq && q.size() != DEPTH));
    chk("empty_n", 32'(empty_n), 32'(q.size() != 0));
    chk("dout", 32'(dout), 32'(head));
`ifdef RACALC_FIFO_STATS_EN
    chk("stat_wr_cnt", stat_wr_cnt, 32'(m_wr));
    chk("stat_rd_cnt", stat_rd_cnt, 32'(m_rd));
    chk("stat_hwm", 32'(stat_hwm), 32'(m_hwm));
    chk("stat_wr_drop", 32'(stat_wr_drop), 32'(m_drop));
`endif
  endtask

  // One clock: inputs already driven; advance, update model, compare, then release strobes.
  task automatic tick();
    bit w_acc, r_acc;
    w_acc = wr && !m_rstq && (q.size() != DEPTH);
    r_acc = rd && (q.size() != 0);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_rstq = 1'b1;
      m_wr = 0; m_rd = 0; m_hwm = 0; m_drop = 0;
    end else begin
      if (wr && !w_acc && m_drop != 32'hFFFF) m_drop++;
      if (r_acc) void'(q.pop_front());
      if (w_acc) q.push_back(din);
      if (w_acc) m_wr++;
      if (r_acc) m_rd++;
      m_rstq = 1'b0;
      if (q.size() > m_hwm) m_hwm = q.size();
    end
    check_state();
    $display("[TB] t=%0t wr=%0b rd=%0b din=%02h -> level=%0d full_n=%0b empty_n=%0b dout=%02h",
             $time, wr, rd, din, level, full_n, empty_n, dout);
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic cyc(input bit w, input logic [7:0] d, input bit r);
    wr = w; din = d; rd = r;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit saw_ab;

    // Reset held for 100 cycles.
    rst = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("rst_full_n", 32'(full_n), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    tick();
    chk("release_full_n", 32'(full_n), 32'd1);

    // Single job.
    cyc(1, 8'h5A, 0);
    chk("single_empty_n", 32'(empty_n), 32'd1);
    chk("single_dout", 32'(dout), 32'h5A);
    cyc(0, 8'h00, 1);
    chk("single_after_read_empty_n", 32'(empty_n), 32'd0);
    chk("single_after_read_dout", 32'(dout), 32'h00);

    // Fill, overrun, drain.
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_full_n", 32'(full_n), 32'd0);
    cyc(1, 8'hFF, 0);
    chk("overrun_level", 32'(level), 32'd16);
`ifdef RACALC_FIFO_STATS_EN
    chk("overrun_drop", 32'(stat_wr_drop), 32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(dout), 32'(i));
      cyc(0, 8'h00, 1);
    end
    chk("drain_empty_n", 32'(empty_n), 32'd0);

    // Prefill 3, then 100 cycles of simultaneous read and write.
    for (int i = 0; i < 3; i++) cyc(1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 100; i++) begin
      cyc(1, 8'($urandom_range(0, 255)), 1);
      chk("stream_level", 32'(level), 32'd3);
    end
`ifdef RACALC_FIFO_STATS_EN
    chk("stream_cnt_delta", stat_wr_cnt - stat_rd_cnt, 32'd3);
`endif

    // Random traffic with random strobes.
    for (int i = 0; i < 300; i++)
      cyc(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));

    // Full with simultaneous read: only the read may be accepted.
    while (q.size() != 0) cyc(0, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h40 + i), 0);
    chk("full_pre_level", 32'(level), 32'd16);
    cyc(1, 8'hAB, 1);
    chk("full_rw_level", 32'(level), 32'd15);
    chk("full_rw_full_n", 32'(full_n), 32'd1);
    saw_ab = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      b = dout;
      if (b == 8'hAB) saw_ab = 1'b1;
      chk("full_rw_order", 32'(b), 32'(8'h40 + i));
      cyc(0, 8'h00, 1);
    end
    chk("full_rw_no_ab", 32'(saw_ab), 32'd0);
    chk("full_rw_empty_n", 32'(empty_n), 32'd0);

    // Mid-run reset at level 7.
    for (int i = 0; i < 7; i++) cyc(1, 8'($urandom_range(0, 255)), 0);
    chk("midrst_pre_level", 32'(level), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_empty_n", 32'(empty_n), 32'd0);
`ifdef RACALC_FIFO_STATS_EN
    chk("midrst_wr_cnt", stat_wr_cnt, 32'd0);
    chk("midrst_hwm", 32'(stat_hwm), 32'd0);
`endif
    tick();
    chk("midrst_full_n", 32'(full_n), 32'd1);
    cyc(1, 8'h33, 0);
    chk("midrst_first_dout", 32'(dout), 32'h33);
    cyc(0, 8'h00, 1);
    chk("midrst_final_empty_n", 32'(empty_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
